// File: rtl/fetch_line_responder_pkg.sv
// Shared types and helpers for the instruction-fetch line responder.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AREQ = 2'd1,
        FILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/fetch_line_responder_line_buf.sv
// Single-line instruction storage: data words, tag and valid bit,
// one write port and a combinational read/tag-match port.
module fetch_line_buf #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = 2,
    parameter int TAG_W      = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inv,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             set_valid,
    input  logic             we,
    input  logic [OFF_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [OFF_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             tag_hit,
    output logic [31:0]      rd_data
);

    logic [31:0]      r_mem [LINE_WORDS];
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;

    // Invalidate and tag capture happen together when a miss starts a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else if (inv) begin
            r_tag   <= tag_in;
            r_valid <= 1'b0;
        end else if (set_valid) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign tag_hit = r_valid && (r_tag == rd_tag);
    assign rd_data = r_mem[rd_idx];

endmodule

// File: rtl/fetch_line_responder.sv
// Instruction-fetch responder: serves hits from a one-line buffer and refills
// it with a read burst on a miss. Optional counters: define FETCH_PERF_EN.
module fetch_line_responder
    import fetch_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_inst,
    output logic              fetch_valid,
    output logic              fetch_stall,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rlast,
    output logic              mem_rready,
    output logic              fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int TAG_W = ADDR_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [OFF_W-1:0]  r_beat;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_err;

    logic [OFF_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_tag_hit;
    logic [31:0]       w_rd_data;
    logic              w_hit;
    logic              w_miss;
    logic              w_beat_we;
    logic              w_last_beat;
    logic              w_unused_addr_bits;

    assign w_idx              = fetch_addr[OFF_W+1:2];
    assign w_tag              = fetch_addr[ADDR_W-1:OFF_W+2];
    assign w_unused_addr_bits = ^fetch_addr[1:0];

    fetch_line_buf #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_W      (OFF_W),
        .TAG_W      (TAG_W)
    ) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .inv       (w_miss),
        .tag_in    (w_tag),
        .set_valid (w_last_beat),
        .we        (w_beat_we),
        .waddr     (r_beat),
        .wdata     (mem_rdata),
        .rd_idx    (w_idx),
        .rd_tag    (w_tag),
        .tag_hit   (w_tag_hit),
        .rd_data   (w_rd_data)
    );

    assign w_hit       = (r_state == IDLE) && fetch_req && w_tag_hit;
    assign fetch_valid = w_hit;
    assign fetch_inst  = w_hit ? w_rd_data : 32'h0;
    assign fetch_stall = (fetch_req && !w_hit) || (r_state != IDLE);
    assign mem_araddr  = r_araddr;
    assign fetch_err   = r_err;

    always_comb begin
        w_state_next = r_state;
        w_miss       = 1'b0;
        w_beat_we    = 1'b0;
        w_last_beat  = 1'b0;
        mem_arvalid  = 1'b0;
        mem_rready   = 1'b0;
        case (r_state)
            IDLE: begin
                if (fetch_req && !w_hit) begin
                    w_miss       = 1'b1;
                    w_state_next = AREQ;
                end
            end
            AREQ: begin
                mem_arvalid = 1'b1;
                if (mem_arready) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    w_beat_we = 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_last_beat  = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_araddr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_miss) begin
                r_araddr <= {w_tag, {(OFF_W + 2){1'b0}}};
            end
            if (r_state == AREQ && mem_arready) begin
                r_beat <= '0;
            end else if (w_beat_we) begin
                r_beat <= r_beat + 1'b1;
            end
            // rlast must coincide exactly with the final beat; the burst still ends by count.
            if (w_beat_we && (mem_rlast != (r_beat == LAST_BEAT))) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count    <= '0;
            r_miss_count   <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_hit && r_hit_count != 32'hFFFF_FFFF) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && r_miss_count != 32'hFFFF_FFFF) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (fetch_stall && r_stall_cycles != 32'hFFFF_FFFF) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder (default build, 4-word lines).
module tb_fetch_line_responder;

    logic        clk;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        fetch_stall;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_rready;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    fetch_line_responder #(
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_inst  (fetch_inst),
        .fetch_valid (fetch_valid),
        .fetch_stall (fetch_stall),
        .mem_arvalid (mem_arvalid),
        .mem_araddr  (mem_araddr),
        .mem_arready (mem_arready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rlast   (mem_rlast),
        .mem_rready  (mem_rready),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_rlast  = last;
        tick();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic accept_ar();
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = 32'h0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(fetch_stall), 32'd0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_inst", fetch_inst, 32'h0);
        chk("rst_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rst_araddr", mem_araddr, 32'h0);
        chk("rst_rready", 32'(mem_rready), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        #2 rst_n = 1'b1;

        // 1: cold miss at 0x0, refill, then hit
        tick();
        fetch_req = 1'b1; fetch_addr = 32'h0; #1;
        chk("t1_miss_stall", 32'(fetch_stall), 32'd1);
        chk("t1_miss_valid", 32'(fetch_valid), 32'd0);
        tick();
        chk("t1_arvalid", 32'(mem_arvalid), 32'd1);
        chk("t1_araddr", mem_araddr, 32'h0);
        accept_ar();
        chk("t1_rready", 32'(mem_rready), 32'd1);
        chk("t1_arvalid_off", 32'(mem_arvalid), 32'd0);
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        beat(32'h44, 1'b1);
        chk("t1_hit_valid", 32'(fetch_valid), 32'd1);
        chk("t1_hit_inst", fetch_inst, 32'h11);
        chk("t1_hit_stall", 32'(fetch_stall), 32'd0);
        chk("t1_err", 32'(fetch_err), 32'd0);

        // 2: sweep the remaining words of the line
        tick(); fetch_addr = 32'h4; #1;
        chk("t2_inst4", fetch_inst, 32'h22);
        chk("t2_stall4", 32'(fetch_stall), 32'd0);
        tick(); fetch_addr = 32'h8; #1;
        chk("t2_inst8", fetch_inst, 32'h33);
        tick(); fetch_addr = 32'hC; #1;
        chk("t2_instC", fetch_inst, 32'h44);
        chk("t2_validC", 32'(fetch_valid), 32'd1);
        chk("t2_arvalid", 32'(mem_arvalid), 32'd0);

        // idle without request: no stall, no bus request
        tick(); fetch_req = 1'b0; fetch_addr = 32'h40; #1;
        chk("noreq_stall", 32'(fetch_stall), 32'd0);
        chk("noreq_valid", 32'(fetch_valid), 32'd0);
        tick();
        chk("noreq_arvalid", 32'(mem_arvalid), 32'd0);

        // 3: cross-line miss with arready held low
        fetch_req = 1'b1; fetch_addr = 32'h10; #1;
        chk("t3_miss_stall", 32'(fetch_stall), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_arvalid_hold", 32'(mem_arvalid), 32'd1);
            chk("t3_araddr_hold", mem_araddr, 32'h10);
            chk("t3_stall_hold", 32'(fetch_stall), 32'd1);
            tick();
        end
        accept_ar();

        // 4: redirect to 0x0 mid-fill; burst completes, then 0x0 misses again
        beat(32'hA0, 1'b0);
        fetch_addr = 32'h0; #1;
        chk("t4_stall_fill", 32'(fetch_stall), 32'd1);
        chk("t4_valid_fill", 32'(fetch_valid), 32'd0);
        beat(32'hA1, 1'b0);
        beat(32'hA2, 1'b0);
        beat(32'hA3, 1'b1);
        chk("t4_remiss_stall", 32'(fetch_stall), 32'd1);
        chk("t4_remiss_valid", 32'(fetch_valid), 32'd0);
        tick();
        chk("t4_arvalid", 32'(mem_arvalid), 32'd1);
        chk("t4_araddr", mem_araddr, 32'h0);
        chk("t4_err", 32'(fetch_err), 32'd0);

        // 5: rlast on beat 1 raises a sticky error; line still fills
        accept_ar();
        beat(32'h55, 1'b0);
        chk("t5_err_b0", 32'(fetch_err), 32'd0);
        beat(32'h66, 1'b1);
        chk("t5_err_b1", 32'(fetch_err), 32'd1);
        chk("t5_stall_b1", 32'(fetch_stall), 32'd1);
        beat(32'h77, 1'b0);
        beat(32'h88, 1'b0);
        chk("t5_hit_valid", 32'(fetch_valid), 32'd1);
        chk("t5_hit_inst", fetch_inst, 32'h55);
        tick(); fetch_addr = 32'hC; #1;
        chk("t5_inst_last", fetch_inst, 32'h88);
        tick(); tick();
        chk("t5_err_sticky", 32'(fetch_err), 32'd1);

        // 6: reset in the middle of a fill
        fetch_addr = 32'h20; #1;
        chk("t6_miss_stall", 32'(fetch_stall), 32'd1);
        tick();
        chk("t6_araddr", mem_araddr, 32'h20);
        accept_ar();
        beat(32'h99, 1'b0);
        beat(32'h9A, 1'b0);
        chk("t6_rready_pre", 32'(mem_rready), 32'd1);
        #2;
        rst_n = 1'b0; fetch_req = 1'b0; #1;
        chk("t6_rst_arvalid", 32'(mem_arvalid), 32'd0);
        chk("t6_rst_rready", 32'(mem_rready), 32'd0);
        chk("t6_rst_stall", 32'(fetch_stall), 32'd0);
        chk("t6_rst_err", 32'(fetch_err), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        fetch_req = 1'b1; fetch_addr = 32'h20; #1;
        chk("t6_post_valid", 32'(fetch_valid), 32'd0);
        chk("t6_post_stall", 32'(fetch_stall), 32'd1);
        tick();
        chk("t6_post_arvalid", 32'(mem_arvalid), 32'd1);
        chk("t6_post_araddr", mem_araddr, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
